prng_multi: RTL and testbench
=============================

Name: prng_multi

Overview:
- Parametrised multi-channel pseudorandom symbol generator for the Genius game datapath.
- Runs SYM_BITS independent Galois LFSRs; each channel contributes one bit of every symbol.
- Keeps a replay seed so the game FSM can regenerate the round's sequence (rerun).
- Supports seed scrambling while idle (randomize), a LOOKAHEAD-symbol preview bus (cheat), and a step-position counter.

Parameters:
- SYM_BITS, 2: channels and bits per symbol (1..8).
- LFSR_W, 16: width of each channel LFSR.
- TAPS, 16'hB400: Galois feedback mask, LFSR_W bits, maximal length for the default width.
- SEED_BASE, 16'hACE1: base fill. The reset fill of channel i is SEED_BASE XOR i; if that value is zero it is forced to 1.
- LOOKAHEAD, 3: number of future symbols on the cheat bus (1..8).
- POS_W, 8: width of the step-position counter.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high; clears all state to defaults.
- step, in, 1: advance the sequence by one symbol.
- rerun, in, 1: reload every channel state from its saved seed.
- randomize, in, 1: free-run and capture a new seed while high.
- random, out, SYM_BITS: current symbol; bit i is bit 0 of channel i state.
- cheat, out, SYM_BITS*LOOKAHEAD: next LOOKAHEAD symbols. Symbol k (k=1..LOOKAHEAD) sits at bits [k*SYM_BITS-1 : (k-1)*SYM_BITS].
- seq_pos, out, POS_W: steps taken since the last reset, rerun or randomize cycle.

Behaviour:
- Galois advance function, per channel: s' = (s >> 1) XOR (s[0] ? TAPS : 0).
- Per channel, two registers: state[LFSR_W] and seed[LFSR_W].
- A position counter pos[POS_W] is shared by all channels.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = seed = channel fill.
  - pos = 0.
  - Consequently random and cheat show values derived from the fills; seq_pos = 0.
- Command priority, sampled on each rising clk: randomize > rerun > step > hold.
- randomize = 1, every cycle high:
  - state <= advance(state).
  - seed <= advance(state), so the seed tracks state.
  - pos <= 0.
  - step and rerun are ignored.
  - The seed left when randomize falls is the new replay point.
- rerun = 1 (randomize = 0):
  - state <= seed.
  - pos <= 0.
  - step is ignored in the same cycle.
- step = 1 only:
  - state <= advance(state); seed unchanged.
  - pos <= pos + 1, wrapping from 2^POS_W-1 to 0.
- No command: all registers hold.
- Output timing:
  - random, cheat and seq_pos are combinational from the registers, so updates are visible the cycle after the command edge.
  - There is no other latency.
- cheat is computed by applying the advance function k times (k=1..LOOKAHEAD) to each state; it does not change any register.
- A zero state is unreachable, since fills are forced nonzero and Galois with nonzero state never reaches zero. No lock-up recovery is required.
- Commands are level-sampled. A step held high for N cycles advances N symbols; the edge detection lives in the caller.
- A parameter violation (SYM_BITS or LOOKAHEAD out of range, TAPS width mismatch) is an elaboration error.

Test Plan:
- Reset, default params:
  - Channel states are ACE1 and ACE0; random = 2'b01.
  - cheat = 6'b000000, because the next states are E270/5670, 7138/2B38 and 389C/159C.
  - seq_pos = 0.
- Five single-cycle step pulses from reset:
  - States after each step: E270/5670, 7138/2B38, 389C/159C, 1C4E/0ACE, 0E27/0567.
  - random after the fifth step = 2'b11; seq_pos = 5.
  - A sixth step gives B313/B6B3.
- After five steps, pulse rerun:
  - States return to ACE1/ACE0; random = 2'b01; seq_pos = 0.
  - Repeat the steps; the sequence is identical.
- Hold randomize for 3 cycles from reset, then pulse rerun:
  - State and seed are both 389C/159C; seq_pos = 0.
  - rerun leaves 389C/159C and replays from there.
- Priority checks:
  - randomize + rerun + step together: randomize behaviour only.
  - rerun + step together: reload, no advance, seq_pos = 0.
- Edge cases:
  - Assert reset asynchronously between clock edges mid-sequence: outputs return to reset values without waiting for clk.
  - Step 256 times: seq_pos wraps 255 -> 0.

Source files
------------

// File: rtl/prng_multi.sv
// prng_multi: multi-channel pseudorandom symbol generator.
//
// SYM_BITS independent Galois LFSRs run in lockstep. Each channel supplies
// one bit of every symbol. A per-channel replay seed lets the game FSM
// regenerate the round's sequence. While randomize is high the LFSRs
// free-run and the seed follows them, so the value left when randomize
// falls becomes the new replay point.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; loads the fills into state and seed
//   step       advance one symbol (level-sampled)
//   rerun      reload every channel from its saved seed
//   randomize  free-run and capture a new seed while high
//   random     current symbol, bit i = bit 0 of channel i
//   cheat      next LOOKAHEAD symbols, symbol k at [k*SYM_BITS-1 -: SYM_BITS]
//   seq_pos    steps taken since the last reset, rerun or randomize cycle
module prng_multi #(
  parameter int SYM_BITS  = 2,
  parameter int LFSR_W    = 16,
  parameter     TAPS      = 16'hB400,
  parameter     SEED_BASE = 16'hACE1,
  parameter int LOOKAHEAD = 3,
  parameter int POS_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step,
  input  logic                          rerun,
  input  logic                          randomize,
  output logic [SYM_BITS-1:0]           random,
  output logic [SYM_BITS*LOOKAHEAD-1:0] cheat,
  output logic [POS_W-1:0]              seq_pos
);

  if (SYM_BITS < 1 || SYM_BITS > 8) begin : g_err_sym_bits
    $error("prng_multi: SYM_BITS must be in 1..8");
  end
  if (LOOKAHEAD < 1 || LOOKAHEAD > 8) begin : g_err_lookahead
    $error("prng_multi: LOOKAHEAD must be in 1..8");
  end
  if ($bits(TAPS) != LFSR_W) begin : g_err_taps
    $error("prng_multi: TAPS width must equal LFSR_W");
  end

  localparam logic [LFSR_W-1:0] TAPS_L = LFSR_W'(TAPS);
  localparam logic [LFSR_W-1:0] BASE_L = LFSR_W'(SEED_BASE);

  logic [SYM_BITS-1:0][LFSR_W-1:0] state;
  logic [SYM_BITS-1:0][LFSR_W-1:0] seed;
  logic [POS_W-1:0]                pos;

  function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS_L : '0);
  endfunction

  // Channel fill; an all-zero value would lock the LFSR, so it becomes 1.
  function automatic logic [LFSR_W-1:0] fill(input int ch);
    logic [LFSR_W-1:0] f;
    f = BASE_L ^ LFSR_W'(ch);
    if (f == '0) f = LFSR_W'(1);
    return f;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < SYM_BITS; c++) begin
        state[c] <= fill(c);
        seed[c]  <= fill(c);
      end
      pos <= '0;
    end else if (randomize) begin
      // Seed shadows the running state so the last value becomes the replay point.
      for (int c = 0; c < SYM_BITS; c++) begin
        state[c] <= advance(state[c]);
        seed[c]  <= advance(state[c]);
      end
      pos <= '0;
    end else if (rerun) begin
      state <= seed;
      pos   <= '0;
    end else if (step) begin
      for (int c = 0; c < SYM_BITS; c++) begin
        state[c] <= advance(state[c]);
      end
      pos <= pos + POS_W'(1);
    end
  end

  always_comb begin
    random = '0;
    for (int c = 0; c < SYM_BITS; c++) begin
      random[c] = state[c][0];
    end
  end

  // Preview: walk each channel forward k steps without touching the registers.
  always_comb begin
    logic [LFSR_W-1:0] t;
    cheat = '0;
    t     = '0;
    for (int c = 0; c < SYM_BITS; c++) begin
      t = state[c];
      for (int k = 0; k < LOOKAHEAD; k++) begin
        t = advance(t);
        cheat[k*SYM_BITS + c] = t[0];
      end
    end
  end

  assign seq_pos = pos;

endmodule

// File: tb/tb_prng_multi.sv
module tb_prng_multi;

  logic       clk;
  logic       reset;
  logic       step;
  logic       rerun;
  logic       randomize;
  logic [1:0] random;
  logic [5:0] cheat;
  logic [7:0] seq_pos;

  int total;
  int bad;

  prng_multi dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .rerun     (rerun),
    .randomize (randomize),
    .random    (random),
    .cheat     (cheat),
    .seq_pos   (seq_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one command for one clock edge, then sample 1 ns after the edge.
  task automatic tick(input logic rnd, input logic rr, input logic st);
    @(negedge clk);
    randomize = rnd;
    rerun     = rr;
    step      = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    randomize = 1'b0;
    rerun     = 1'b0;
    step      = 1'b0;
  endtask

  function automatic logic [63:0] st2(input logic [15:0] c0, input logic [15:0] c1);
    return {32'h0, c1, c0};
  endfunction

  logic [15:0] e0 [5];
  logic [15:0] e1 [5];

  initial begin
    total = 0;
    bad   = 0;
    e0[0] = 16'hE270; e1[0] = 16'h5670;
    e0[1] = 16'h7138; e1[1] = 16'h2B38;
    e0[2] = 16'h389C; e1[2] = 16'h159C;
    e0[3] = 16'h1C4E; e1[3] = 16'h0ACE;
    e0[4] = 16'h0E27; e1[4] = 16'h0567;

    reset = 1'b1; step = 1'b0; rerun = 1'b0; randomize = 1'b0;
    #3;
    chk("reset_state", 64'(dut.state), st2(16'hACE1, 16'hACE0));
    chk("reset_random", 64'(random), 64'h1);
    chk("reset_cheat", 64'(cheat), 64'h0);
    chk("reset_pos", 64'(seq_pos), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // five steps from reset
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      idle();
      chk($sformatf("step%0d_state", i + 1), 64'(dut.state), st2(e0[i], e1[i]));
    end
    chk("step5_random", 64'(random), 64'h3);
    chk("step5_pos", 64'(seq_pos), 64'd5);
    chk("step5_cheat", 64'(cheat), 64'h0F);
    tick(1'b0, 1'b0, 1'b1);
    idle();
    chk("step6_state", 64'(dut.state), st2(16'hB313, 16'hB6B3));

    // rerun returns to the reset fills and replays identically
    tick(1'b0, 1'b1, 1'b0);
    idle();
    chk("rerun_state", 64'(dut.state), st2(16'hACE1, 16'hACE0));
    chk("rerun_random", 64'(random), 64'h1);
    chk("rerun_pos", 64'(seq_pos), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      idle();
      chk($sformatf("replay%0d_state", i + 1), 64'(dut.state), st2(e0[i], e1[i]));
    end
    chk("replay_pos", 64'(seq_pos), 64'd5);

    // randomize for three cycles from reset
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    idle();
    chk("rnd_state", 64'(dut.state), st2(16'h389C, 16'h159C));
    chk("rnd_seed", 64'(dut.seed), st2(16'h389C, 16'h159C));
    chk("rnd_pos", 64'(seq_pos), 64'h0);
    tick(1'b0, 1'b0, 1'b1);
    idle();
    chk("rnd_step_state", 64'(dut.state), st2(16'h1C4E, 16'h0ACE));
    tick(1'b0, 1'b1, 1'b0);
    idle();
    chk("rnd_rerun_state", 64'(dut.state), st2(16'h389C, 16'h159C));
    tick(1'b0, 1'b0, 1'b1);
    idle();
    chk("rnd_replay_state", 64'(dut.state), st2(16'h1C4E, 16'h0ACE));
    chk("rnd_replay_pos", 64'(seq_pos), 64'd1);

    // all three commands together: randomize wins
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("pri_pre_pos", 64'(seq_pos), 64'd2);
    tick(1'b1, 1'b1, 1'b1);
    idle();
    chk("pri_all_state", 64'(dut.state), st2(16'h389C, 16'h159C));
    chk("pri_all_seed", 64'(dut.seed), st2(16'h389C, 16'h159C));
    chk("pri_all_pos", 64'(seq_pos), 64'h0);

    // rerun + step: reload only
    tick(1'b0, 1'b0, 1'b1);
    chk("pri_mid_state", 64'(dut.state), st2(16'h1C4E, 16'h0ACE));
    tick(1'b0, 1'b1, 1'b1);
    idle();
    chk("pri_rr_state", 64'(dut.state), st2(16'h389C, 16'h159C));
    chk("pri_rr_pos", 64'(seq_pos), 64'h0);

    // hold: no command leaves everything alone
    tick(1'b0, 1'b0, 1'b0);
    chk("hold_state", 64'(dut.state), st2(16'h389C, 16'h159C));

    // asynchronous reset between edges
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    idle();
    #1;
    reset = 1'b1;
    #1;
    chk("async_state", 64'(dut.state), st2(16'hACE1, 16'hACE0));
    chk("async_random", 64'(random), 64'h1);
    chk("async_cheat", 64'(cheat), 64'h0);
    chk("async_pos", 64'(seq_pos), 64'h0);
    @(negedge clk); reset = 1'b0;

    // position counter wrap
    for (int i = 0; i < 255; i++) tick(1'b0, 1'b0, 1'b1);
    chk("wrap_255", 64'(seq_pos), 64'd255);
    tick(1'b0, 1'b0, 1'b1);
    chk("wrap_0", 64'(seq_pos), 64'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
